// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the 5-stage MIPS core: load-use stall, taken-branch flush, mul/div freeze.
// Optional performance stall counter is enabled by defining HAZARD_STALL_PERF_EN.
module hazard_stall_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_md_start,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             pr1_write,
    output logic             pr1_flush,
    output logic             pr2_bubble,
    output logic             pr2_hold,
    output logic             pr3_bubble,
    output logic             md_busy,
    output logic             md_done
`ifdef HAZARD_STALL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    // A latency of 0 behaves like 1: the freeze always lasts at least one cycle.
    localparam int MD_LAT_EFF = (MD_LATENCY < 1) ? 1 : MD_LATENCY;
    localparam int MD_CW      = (MD_LAT_EFF > 1) ? $clog2(MD_LAT_EFF) : 1;
    localparam logic [MD_CW-1:0] MD_LOAD = MD_CW'(MD_LAT_EFF - 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MD_WAIT = 2'b01
    } stateT;

    stateT              state;
    stateT              nextState;
    logic [MD_CW-1:0]   mdCnt;
    logic [MD_CW-1:0]   mdCntNext;
    logic               loadUse;

    // Load in ID/EX whose destination feeds the instruction in IF/ID; $zero never conflicts.
    assign loadUse = ex_mem_read && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // State and mul/div counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            mdCnt <= {MD_CW{1'b0}};
        end else begin
            state <= nextState;
            mdCnt <= mdCntNext;
        end
    end

    // Next-state and pipeline control; reset overrides every input so control is safe immediately.
    always_comb begin
        nextState  = state;
        mdCntNext  = mdCnt;
        pc_write   = 1'b1;
        pr1_write  = 1'b1;
        pr1_flush  = 1'b0;
        pr2_bubble = 1'b0;
        pr2_hold   = 1'b0;
        pr3_bubble = 1'b0;
        md_busy    = 1'b0;
        md_done    = 1'b0;
        if (!rst_n) begin
            nextState = RUN;
            mdCntNext = {MD_CW{1'b0}};
        end else begin
            case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        pr1_flush  = 1'b1;
                        pr2_bubble = 1'b1;
                    end else if (ex_md_start) begin
                        nextState = MD_WAIT;
                        mdCntNext = MD_LOAD;
                    end else if (loadUse) begin
                        // The bubble clears ex_mem_read next cycle, so this costs exactly one cycle.
                        pc_write   = 1'b0;
                        pr1_write  = 1'b0;
                        pr2_bubble = 1'b1;
                    end else begin
                        nextState = RUN;
                    end
                end
                MD_WAIT: begin
                    pc_write   = 1'b0;
                    pr1_write  = 1'b0;
                    pr2_hold   = 1'b1;
                    pr3_bubble = 1'b1;
                    md_busy    = 1'b1;
                    if (mdCnt == {MD_CW{1'b0}}) begin
                        md_done   = 1'b1;
                        nextState = RUN;
                    end else begin
                        mdCntNext = mdCnt - MD_CW'(1);
                    end
                end
                default: begin
                    nextState = RUN;
                    mdCntNext = {MD_CW{1'b0}};
                end
            endcase
        end
    end

`ifdef HAZARD_STALL_PERF_EN
    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= {CNT_W{1'b0}};
        end else if (!pc_write && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end else begin
            stall_cnt <= stall_cnt;
        end
    end
`endif

endmodule
